gray_mem_arbiter: RTL and testbench
===================================

# gray_mem_arbiter

Two-port read arbiter that shares the single gray-image memory port (128x128, 8-bit pixels, 14-bit address) between the LBP window engine and a second reader such as a histogram or debug scanner. Each requester issues single-beat reads. The arbiter grants in bursts of up to one 3x3 window. It forwards memory read data to the owner one cycle later, tagged by a registered owner bit. It sits between the requesters and the image memory's gray_req/gray_ready/gray_addr/gray_data port.

## Interface
- ADDR_W, 14, memory address width
- DATA_W, 8, pixel width
- MAX_BURST, 9, maximum consecutive beats granted to one requester before forced re-arbitration (range 1..15)
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- m0_req  in  1  requester 0 (LBP engine) wants one read this cycle
- m0_addr  in  ADDR_W  requester 0 read address
- m0_gnt  out  1  requester 0 beat accepted this cycle
- m0_rvalid  out  1  m0_rdata valid (beat accepted previous cycle)
- m0_rdata  out  DATA_W  read data for requester 0
- m1_req, m1_addr, m1_gnt, m1_rvalid, m1_rdata: same as m0, for requester 1
- mem_ready  in  1  memory can accept a read this cycle
- mem_req  out  1  read strobe to memory
- mem_addr  out  ADDR_W  read address to memory
- mem_data  in  DATA_W  memory read data, valid the cycle after mem_req&mem_ready

## Operation
- States: IDLE, OWN0, OWN1. Reset: IDLE, burst_cnt=0, rr_last=1, rd_pend=0, rd_owner=0.
- IDLE: if only mX_req, go to OWNX. If both are high, pick by policy (see Configuration). If neither, stay.
- Arbitration uses the registered state; grant is issued in the same cycle as the transition into OWNX (no dead cycle). The IDLE decision is computed combinationally.
- In OWNX: mem_req = mX_req, mem_addr = mX_addr. mX_gnt = mX_req & mem_ready. The other gnt is 0.
- Beat accepted (gnt=1): burst_cnt += 1. rd_pend<=1, rd_owner<=X.
- Release OWNX when any of the following holds, then apply the IDLE rule to the next cycle's requests via a transition through IDLE-equivalent logic:
  - mX_req is low.
  - A beat is accepted with burst_cnt==MAX_BURST-1.
- On release: burst_cnt<=0, rr_last<=X.
- After a forced release, if the other requester is waiting it wins next. If it is not waiting, the same requester may regain ownership with a fresh burst.
- mem_ready low: no gnt, burst_cnt and state hold. Waiting does not count toward the burst.
- Read return: mX_rvalid = rd_pend & (rd_owner==X). mX_rdata = mem_data when that rvalid is high, else 0. rd_pend<=0 unless a new beat is accepted.
- Address and data paths pass through without width change. burst_cnt is 4-bit saturating-free (bounded by MAX_BURST).

## Timing
- Grant-to-data latency: exactly 1 cycle. Back-to-back beats give 1 beat/cycle throughput.
- Ownership change costs 0 idle cycles when the other requester is waiting.
- All outputs are 0 during and immediately after reset. An in-flight read at reset is discarded (no rvalid).
- Requester must hold mX_req/mX_addr stable until mX_gnt. Dropping req without gnt is legal and releases ownership.
- Simultaneous release and other-request in the same cycle: the other requester is granted next cycle.

## Configuration
- GRAY_ARB_RR_EN defined: round-robin tie-break. On simultaneous requests in IDLE, grant the requester != rr_last.
- GRAY_ARB_RR_EN undefined: fixed priority, requester 0 always wins ties. rr_last is still maintained but unused. Forced release still occurs after MAX_BURST, but requester 0 immediately regains ownership if still requesting.

## Structure
- Shared package gray_arb_pkg: state enum (IDLE/OWN0/OWN1), ADDR_W/DATA_W defaults, MAX_BURST default 9.
- One natural sub-module: gray_arb_rdmux (registered rd_pend/rd_owner plus rvalid/rdata steering). The rest is flat.

## Test plan
- Single requester: m0_req high for 20 cycles with addresses 0..19, mem_ready=1. Expected: m0_gnt high on 9 cycles, low for 0 cycles, then regains. m0_rvalid follows each gnt by 1 cycle with matching data.
- Contention (RR build): both requesting from reset release. Expected: OWN0 for 9 beats, then OWN1 for 9 beats, alternating. No cycle has both gnts high.
- Contention (fixed build): both requesting. Expected: m0 gets every beat and m1_gnt never asserts.
- mem_ready stall: ownership at burst_cnt=4, mem_ready low for 3 cycles. Expected: no gnt, burst_cnt stays 4, and 5 more beats follow before release.
- Early drop: m1 owns and drops req after 2 beats while m0 is waiting. Expected: m0_gnt next cycle. m1_rvalid for beat 2 appears concurrently with m0's first gnt.
- Reset mid-burst: assert reset the cycle after a gnt. Expected: no rvalid the next cycle, all outputs 0, state IDLE.

Source files
------------

// File: rtl/gray_arb_pkg.sv
// Shared types and defaults for the gray-image memory read arbiter.
package gray_arb_pkg;

  localparam int unsigned DefAddrW    = 14;
  localparam int unsigned DefDataW    = 8;
  localparam int unsigned DefMaxBurst = 9;

  typedef enum logic [1:0] {
    StIdle,
    StOwn0,
    StOwn1
  } arb_state_e;

  function automatic arb_state_e own_state(input logic owner);
    return owner ? StOwn1 : StOwn0;
  endfunction

endpackage

// File: rtl/gray_mem_arbiter_if.sv
// Requester and memory-side signals of the gray-image read arbiter.
// slave: arbiter view; master: requester/memory environment view.
interface gray_mem_arbiter_if import gray_arb_pkg::*; #(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DATA_W = DefDataW
);
  logic              m0_req;
  logic [ADDR_W-1:0] m0_addr;
  logic              m0_gnt;
  logic              m0_rvalid;
  logic [DATA_W-1:0] m0_rdata;

  logic              m1_req;
  logic [ADDR_W-1:0] m1_addr;
  logic              m1_gnt;
  logic              m1_rvalid;
  logic [DATA_W-1:0] m1_rdata;

  logic              mem_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  modport slave (
    input  m0_req, m0_addr, m1_req, m1_addr, mem_ready, mem_data,
    output m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata, mem_req, mem_addr
  );

  modport master (
    output m0_req, m0_addr, m1_req, m1_addr, mem_ready, mem_data,
    input  m0_gnt, m0_rvalid, m0_rdata, m1_gnt, m1_rvalid, m1_rdata, mem_req, mem_addr
  );
endinterface

// File: rtl/gray_arb_rdmux.sv
// Read-return steering: remembers who owned the last accepted beat and routes
// the memory data back to that requester one cycle later.
module gray_arb_rdmux #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              beat,
  input  logic              beat_owner,
  input  logic [DATA_W-1:0] mem_data,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata
);

  logic rd_pend_q;
  logic rd_owner_q;

  // Reset drops any in-flight read so no stale rvalid escapes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_pend_q  <= 1'b0;
      rd_owner_q <= 1'b0;
    end else begin
      rd_pend_q <= beat;
      if (beat) begin
        rd_owner_q <= beat_owner;
      end
    end
  end

  assign m0_rvalid = rd_pend_q & ~rd_owner_q;
  assign m1_rvalid = rd_pend_q & rd_owner_q;
  assign m0_rdata  = m0_rvalid ? mem_data : '0;
  assign m1_rdata  = m1_rvalid ? mem_data : '0;

endmodule

// File: rtl/gray_mem_arbiter.sv
// Two-requester burst arbiter for the shared gray-image read port.
// Define GRAY_ARB_RR_EN for round-robin tie-break; default is fixed priority to requester 0.
module gray_mem_arbiter import gray_arb_pkg::*; #(
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned DATA_W    = DefDataW,
  parameter int unsigned MAX_BURST = DefMaxBurst
) (
  input logic               clk,
  input logic               reset,
  gray_mem_arbiter_if.slave bus
);

  localparam logic [3:0] LastBeat = 4'(MAX_BURST - 1);

  arb_state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d, cnt_base;
  logic       rr_last_q, rr_last_d;

  logic              cont, drop, cur_owner;
  logic              own_valid, own, beat, active;
  logic [ADDR_W-1:0] sel_addr;

  assign active    = ~reset;
  assign cur_owner = (state_q == StOwn1);

  always_comb begin
    cont = ((state_q == StOwn0) && bus.m0_req) || ((state_q == StOwn1) && bus.m1_req);
    drop = ((state_q == StOwn0) && !bus.m0_req) || ((state_q == StOwn1) && !bus.m1_req);

    // A dropped owner falls straight into the idle decision this same cycle.
    own_valid = 1'b0;
    own       = 1'b0;
    if (cont) begin
      own_valid = 1'b1;
      own       = cur_owner;
    end else if (bus.m0_req && bus.m1_req) begin
      own_valid = 1'b1;
`ifdef GRAY_ARB_RR_EN
      own       = ~rr_last_q;
`else
      own       = 1'b0;
`endif
    end else begin
      own_valid = bus.m0_req | bus.m1_req;
      own       = bus.m1_req;
    end

    cnt_base = cont ? cnt_q : 4'd0;
    beat     = own_valid & bus.mem_ready & active;
    sel_addr = own ? bus.m1_addr : bus.m0_addr;

    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_last_d = rr_last_q;
    if (drop) begin
      state_d   = StIdle;
      cnt_d     = 4'd0;
      rr_last_d = cur_owner;
    end
    if (beat) begin
      if (cnt_base == LastBeat) begin
        state_d   = StIdle;
        cnt_d     = 4'd0;
        rr_last_d = own;
      end else begin
        state_d = own_state(own);
        cnt_d   = cnt_base + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      rr_last_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign bus.mem_req  = own_valid & active;
  assign bus.mem_addr = (own_valid && active) ? sel_addr : '0;
  assign bus.m0_gnt   = beat & ~own;
  assign bus.m1_gnt   = beat & own;

  gray_arb_rdmux #(
    .DATA_W(DATA_W)
  ) u_rdmux (
    .clk       (clk),
    .reset     (reset),
    .beat      (beat),
    .beat_owner(own),
    .mem_data  (bus.mem_data),
    .m0_rvalid (bus.m0_rvalid),
    .m0_rdata  (bus.m0_rdata),
    .m1_rvalid (bus.m1_rvalid),
    .m1_rdata  (bus.m1_rdata)
  );

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// Directed bench for gray_mem_arbiter: vector table plus burst/stall/reset sequences.
module tb_gray_mem_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  gray_mem_arbiter_if #(.ADDR_W(14), .DATA_W(8)) bus ();

  gray_mem_arbiter #(
    .ADDR_W   (14),
    .DATA_W   (8),
    .MAX_BURST(9)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] f(input logic [13:0] a);
    return a[7:0] ^ 8'hA5;
  endfunction

  // Memory model: data for an accepted read appears the following cycle.
  always_ff @(posedge clk) begin
    bus.mem_data <= (bus.mem_req && bus.mem_ready) ? f(bus.mem_addr) : 8'h00;
  end

  typedef struct {
    logic        m0_req;
    logic [13:0] m0_addr;
    logic        m1_req;
    logic [13:0] m1_addr;
    logic        rdy;
    logic        e_g0;
    logic        e_g1;
    logic        e_mreq;
    logic [13:0] e_maddr;
    logic        e_v0;
    logic [7:0]  e_d0;
    logic        e_v1;
    logic [7:0]  e_d1;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic g0, input logic g1, input logic mreq,
                         input logic [13:0] maddr, input logic v0, input logic [7:0] d0,
                         input logic v1, input logic [7:0] d1);
    chk({tag, ".m0_gnt"}, 32'(bus.m0_gnt), 32'(g0));
    chk({tag, ".m1_gnt"}, 32'(bus.m1_gnt), 32'(g1));
    chk({tag, ".mem_req"}, 32'(bus.mem_req), 32'(mreq));
    chk({tag, ".mem_addr"}, 32'(bus.mem_addr), 32'(maddr));
    chk({tag, ".m0_rvalid"}, 32'(bus.m0_rvalid), 32'(v0));
    chk({tag, ".m0_rdata"}, 32'(bus.m0_rdata), 32'(d0));
    chk({tag, ".m1_rvalid"}, 32'(bus.m1_rvalid), 32'(v1));
    chk({tag, ".m1_rdata"}, 32'(bus.m1_rdata), 32'(d1));
  endtask

  task automatic set_in(input logic r0, input logic [13:0] a0, input logic r1,
                        input logic [13:0] a1, input logic rdy);
    bus.m0_req    = r0;
    bus.m0_addr   = a0;
    bus.m1_req    = r1;
    bus.m1_addr   = a1;
    bus.mem_ready = rdy;
  endtask

  // Callers sit at posedge+1; this leaves them there again, in IDLE.
  task automatic do_reset();
    reset = 1'b1;
    set_in(1'b0, 14'd0, 1'b0, 14'd0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [13:0] a0, a1, pa;
    logic        po, pv, eo;
    checks = 0;
    errors = 0;

    // Reset with both requesters asserting: every output must stay 0.
    reset = 1'b1;
    set_in(1'b1, 14'd7, 1'b1, 14'd9, 1'b1);
    @(negedge clk);
    chk_all("reset", 0, 0, 0, 14'd0, 0, 8'd0, 0, 8'd0);
    next_cycle();
    reset = 1'b0;
    set_in(1'b0, 14'd0, 1'b0, 14'd0, 1'b1);
    @(negedge clk);
    chk_all("post_reset", 0, 0, 0, 14'd0, 0, 8'd0, 0, 8'd0);
    next_cycle();

    // Early drop by m1 while m0 waits, then an IDLE stall.
    vecs[0] = '{1'b0, 14'd0, 1'b1, 14'd100, 1'b1,
                1'b0, 1'b1, 1'b1, 14'd100, 1'b0, 8'd0, 1'b0, 8'd0};
    vecs[1] = '{1'b1, 14'd200, 1'b1, 14'd101, 1'b1,
                1'b0, 1'b1, 1'b1, 14'd101, 1'b0, 8'd0, 1'b1, f(14'd100)};
    vecs[2] = '{1'b1, 14'd200, 1'b0, 14'd0, 1'b1,
                1'b1, 1'b0, 1'b1, 14'd200, 1'b0, 8'd0, 1'b1, f(14'd101)};
    vecs[3] = '{1'b1, 14'd201, 1'b0, 14'd0, 1'b1,
                1'b1, 1'b0, 1'b1, 14'd201, 1'b1, f(14'd200), 1'b0, 8'd0};
    vecs[4] = '{1'b0, 14'd0, 1'b0, 14'd0, 1'b1,
                1'b0, 1'b0, 1'b0, 14'd0, 1'b1, f(14'd201), 1'b0, 8'd0};
    vecs[5] = '{1'b1, 14'd5, 1'b0, 14'd0, 1'b0,
                1'b0, 1'b0, 1'b1, 14'd5, 1'b0, 8'd0, 1'b0, 8'd0};
    vecs[6] = '{1'b1, 14'd5, 1'b0, 14'd0, 1'b1,
                1'b1, 1'b0, 1'b1, 14'd5, 1'b0, 8'd0, 1'b0, 8'd0};
    vecs[7] = '{1'b0, 14'd0, 1'b0, 14'd0, 1'b1,
                1'b0, 1'b0, 1'b0, 14'd0, 1'b1, f(14'd5), 1'b0, 8'd0};
    vecs[8] = '{1'b0, 14'd0, 1'b0, 14'd0, 1'b1,
                1'b0, 1'b0, 1'b0, 14'd0, 1'b0, 8'd0, 1'b0, 8'd0};
    for (int i = 0; i < 9; i++) begin
      set_in(vecs[i].m0_req, vecs[i].m0_addr, vecs[i].m1_req, vecs[i].m1_addr, vecs[i].rdy);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), vecs[i].e_g0, vecs[i].e_g1, vecs[i].e_mreq,
              vecs[i].e_maddr, vecs[i].e_v0, vecs[i].e_d0, vecs[i].e_v1, vecs[i].e_d1);
      next_cycle();
    end

    // Single requester: forced release every 9 beats costs no gap.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 14'(i), 1'b0, 14'd0, 1'b1);
      @(negedge clk);
      chk_all($sformatf("single%0d", i), 1, 0, 1, 14'(i), (i > 0),
              (i > 0) ? f(14'(i - 1)) : 8'd0, 0, 8'd0);
      next_cycle();
    end
    set_in(1'b0, 14'd0, 1'b0, 14'd0, 1'b1);
    @(negedge clk);
    chk_all("single_tail", 0, 0, 0, 14'd0, 1, f(14'd19), 0, 8'd0);
    next_cycle();

    // Contention from reset release.
    do_reset();
    a0 = 14'd1000;
    a1 = 14'd2000;
    pv = 1'b0;
    po = 1'b0;
    pa = 14'd0;
    for (int i = 0; i < 36; i++) begin
`ifdef GRAY_ARB_RR_EN
      eo = ((i / 9) % 2) == 1;
`else
      eo = 1'b0;
`endif
      set_in(1'b1, a0, 1'b1, a1, 1'b1);
      @(negedge clk);
      chk_all($sformatf("contend%0d", i), !eo, eo, 1, eo ? a1 : a0,
              pv && !po, (pv && !po) ? f(pa) : 8'd0, pv && po, (pv && po) ? f(pa) : 8'd0);
      pv = 1'b1;
      po = eo;
      pa = eo ? a1 : a0;
      if (eo) a1 = a1 + 14'd1;
      else    a0 = a0 + 14'd1;
      next_cycle();
    end

    // Stall at burst_cnt 4: waiting cycles do not count toward the burst.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_in(1'b0, 14'd0, 1'b1, 14'(300 + i), 1'b1);
      @(negedge clk);
      chk($sformatf("stall_pre%0d.m1_gnt", i), 32'(bus.m1_gnt), 32'd1);
      next_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, 14'd50, 1'b1, 14'd304, 1'b0);
      @(negedge clk);
      chk($sformatf("stall%0d.m0_gnt", i), 32'(bus.m0_gnt), 32'd0);
      chk($sformatf("stall%0d.m1_gnt", i), 32'(bus.m1_gnt), 32'd0);
      chk($sformatf("stall%0d.mem_addr", i), 32'(bus.mem_addr), 32'd304);
      next_cycle();
    end
    for (int i = 0; i < 5; i++) begin
      set_in(1'b1, 14'd50, 1'b1, 14'(304 + i), 1'b1);
      @(negedge clk);
      chk($sformatf("stall_post%0d.m1_gnt", i), 32'(bus.m1_gnt), 32'd1);
      chk($sformatf("stall_post%0d.m0_gnt", i), 32'(bus.m0_gnt), 32'd0);
      next_cycle();
    end
    set_in(1'b1, 14'd50, 1'b1, 14'd309, 1'b1);
    @(negedge clk);
    chk_all("stall_switch", 1, 0, 1, 14'd50, 0, 8'd0, 1, f(14'd308));
    next_cycle();

    // Reset the cycle after a grant: the in-flight read is dropped.
    do_reset();
    set_in(1'b1, 14'd77, 1'b0, 14'd0, 1'b1);
    @(negedge clk);
    chk("rst_mid.gnt", 32'(bus.m0_gnt), 32'd1);
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    chk_all("rst_mid.during", 0, 0, 0, 14'd0, 0, 8'd0, 0, 8'd0);
    next_cycle();
    reset = 1'b0;
    set_in(1'b0, 14'd0, 1'b0, 14'd0, 1'b1);
    @(negedge clk);
    chk_all("rst_mid.after", 0, 0, 0, 14'd0, 0, 8'd0, 0, 8'd0);
    next_cycle();
    // IDLE with rr_last reset to 1: m0 wins the first tie in either build.
    set_in(1'b1, 14'd11, 1'b1, 14'd22, 1'b1);
    @(negedge clk);
    chk_all("rst_mid.tie", 1, 0, 1, 14'd11, 0, 8'd0, 0, 8'd0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
